// File: rtl/led_sopc_oci_dct_pkg.sv
// Shared constants and types for the OCI trace-atom packer.
package led_sopc_oci_dct_pkg;

  localparam int unsigned ATOM_W  = 2;
  localparam int unsigned ATOMS   = 15;
  localparam int unsigned BUF_W   = ATOM_W * ATOMS;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FRAME_W = CNT_W + BUF_W;

  // Fill level at which the buffer must be handed off.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);

  typedef enum logic [1:0] {
    StFill,
    StDrain,
    StDone
  } dct_state_e;

  // Frame as written to trace RAM: fill count above the packed atoms.
  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
  } dct_frame_t;

  // Shift a new atom into the low end; oldest atom moves towards the MSBs.
  function automatic logic [BUF_W-1:0] push_atom(input logic [BUF_W-1:0]  buffer_i,
                                                 input logic [ATOM_W-1:0] atom_i);
    return {buffer_i[BUF_W-ATOM_W-1:0], atom_i};
  endfunction

endpackage

// File: rtl/led_sopc_oci_dct_frame_reg.sv
// One-entry output register holding a frame until the trace-RAM writer takes it.
module led_sopc_oci_dct_frame_reg
  import led_sopc_oci_dct_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  dct_frame_t data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output dct_frame_t data_o,
  output logic       slot_free_o
);

  logic       valid_q, valid_d;
  dct_frame_t data_q, data_d;

  // Load wins over drain so a back-to-back frame keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Frame register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign slot_free_o = !valid_q || ready_i;

endmodule

// File: rtl/led_sopc_nios2_qsys_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit buffers, emits them as 34-bit frames and
// sequences the end-of-test drain.
module led_sopc_nios2_qsys_oci_dct_packer
  import led_sopc_oci_dct_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                trace_enable,
  input  logic                atom_valid,
  input  logic [ATOM_W-1:0]   atom_data,
  output logic                atom_ready,
  input  logic                flush,
  input  logic                test_ending,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [FRAME_W-1:0]  frame_data,
  output logic [BUF_W-1:0]    dct_buffer,
  output logic [CNT_W-1:0]    dct_count,
  output logic                test_has_ended
);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] buffer_q, buffer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic       slot_free;
  logic       xfer;
  logic       pack;
  dct_frame_t frame_in;
  dct_frame_t frame_out;

  // Handshake qualifiers; atom_ready is gated by reset so nothing is taken in reset.
  always_comb begin
    atom_ready = reset_n && (state_q == StFill) && !((cnt_q == CNT_FULL) && !slot_free);
    pack       = atom_valid && atom_ready && trace_enable;
    xfer       = slot_free &&
                 ((cnt_q == CNT_FULL) ||
                  ((flush_pend_q || (state_q == StDrain)) && (cnt_q != '0)));
    frame_in   = '{count: cnt_q, buffer: buffer_q};
  end

  // Buffer and count next state; a same-cycle atom starts the fresh buffer.
  always_comb begin
    buffer_d = buffer_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      buffer_d = '0;
      cnt_d    = '0;
    end
    if (pack) begin
      buffer_d = push_atom(buffer_d, atom_data);
      cnt_d    = cnt_d + CNT_W'(1);
    end
  end

  // Flush request survives only while there is (or will be) something to emit.
  always_comb begin
    flush_pend_d = 1'b0;
    if (!xfer && (flush || flush_pend_q) && ((cnt_q != '0) || pack)) begin
      flush_pend_d = 1'b1;
    end
  end

  // End-of-test sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (test_ending) state_d = StDrain;
      StDrain: if ((cnt_q == '0) && !frame_valid) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StFill;
    endcase
  end

  // Packer and controller state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFill;
      buffer_q     <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buffer_q     <= buffer_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  led_sopc_oci_dct_frame_reg u_frame_reg (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .load_i      (xfer),
    .data_i      (frame_in),
    .ready_i     (frame_ready),
    .valid_o     (frame_valid),
    .data_o      (frame_out),
    .slot_free_o (slot_free)
  );

  assign frame_data     = frame_out;
  assign dct_buffer     = buffer_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = (state_q == StDone);

endmodule

// File: tb/tb_led_sopc_nios2_qsys_oci_dct_packer.sv
// Scoreboard bench for the trace-atom packer.
module tb_led_sopc_nios2_qsys_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        trace_enable = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_data = 2'b00;
  logic        atom_ready;
  logic        flush = 1'b0;
  logic        test_ending = 1'b0;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [33:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];

  led_sopc_nios2_qsys_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .trace_enable   (trace_enable),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] a);
    atom_valid = 1'b1;
    atom_data  = a;
    cyc();
    atom_valid = 1'b0;
  endtask

  // Monitor: every handshake seen on the falling edge is one frame taken next edge.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected frame: got %h, want none", frame_data);
        end else begin
          e = exp_q.pop_front();
          check("frame_data", frame_data, e);
        end
      end
    end
  end

  initial begin
    logic [29:0] m1, m2;
    logic [1:0]  a, a30;
    bit          seen;

    // Reset values
    #12;
    check("rst atom_ready", {33'b0, atom_ready}, 34'd0);
    check("rst dct_count", {30'b0, dct_count}, 34'd0);
    check("rst dct_buffer", {4'b0, dct_buffer}, 34'd0);
    check("rst frame_valid", {33'b0, frame_valid}, 34'd0);
    check("rst frame_data", frame_data, 34'd0);
    check("rst test_has_ended", {33'b0, test_has_ended}, 34'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // T1: 15 atoms back-to-back make one full frame
    frame_ready = 1'b1;
    m1 = '0;
    for (int i = 0; i < 15; i++) begin
      a  = 2'((i % 3) + 1);
      m1 = {m1[27:0], a};
      check("t1 atom_ready", {33'b0, atom_ready}, 34'd1);
      send(a);
    end
    check("t1 count full", {30'b0, dct_count}, 34'd15);
    exp_q.push_back({4'd15, m1});
    cyc();
    cyc();
    check("t1 count after", {30'b0, dct_count}, 34'd0);

    // trace_enable=0 drops the atom
    trace_enable = 1'b0;
    send(2'b11);
    check("disabled count", {30'b0, dct_count}, 34'd0);
    check("disabled buffer", {4'b0, dct_buffer}, 34'd0);
    trace_enable = 1'b1;

    // T2: 3 atoms then flush
    send(2'b10);
    send(2'b01);
    send(2'b11);
    check("t2 buffer", {4'b0, dct_buffer}, 34'b100111);
    check("t2 count", {30'b0, dct_count}, 34'd3);
    exp_q.push_back({4'd3, 24'b0, 6'b100111});
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    cyc();
    check("t2 count after", {30'b0, dct_count}, 34'd0);

    // T3: backpressure with 31 atoms offered
    frame_ready = 1'b0;
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < 30; k++) begin
      a = 2'((k * 3 + 1) % 4);
      if (k < 15) m1 = {m1[27:0], a};
      else        m2 = {m2[27:0], a};
      check("t3 atom_ready", {33'b0, atom_ready}, 34'd1);
      send(a);
    end
    exp_q.push_back({4'd15, m1});
    exp_q.push_back({4'd15, m2});
    check("t3 frame1 presented", frame_data, {4'd15, m1});
    a30 = 2'b10;
    atom_valid = 1'b1;
    atom_data  = a30;
    #1;
    check("t3 backpressure", {33'b0, atom_ready}, 34'd0);
    cyc();
    cyc();
    check("t3 held ready", {33'b0, atom_ready}, 34'd0);
    check("t3 held count", {30'b0, dct_count}, 34'd15);
    check("t3 held frame", frame_data, {4'd15, m1});
    frame_ready = 1'b1;
    cyc();
    atom_valid = 1'b0;
    cyc();
    check("t3 count after", {30'b0, dct_count}, 34'd1);
    check("t3 buffer after", {4'b0, dct_buffer}, {32'b0, a30});
    exp_q.push_back({4'd1, 28'b0, a30});
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    cyc();

    // T4: flush on empty buffer emits nothing and does not linger
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("t4 flush_pend", {33'b0, dut.flush_pend_q}, 34'd0);
    cyc();
    check("t4 no frame", {33'b0, frame_valid}, 34'd0);
    send(2'b11);
    cyc();
    cyc();
    check("t4 no stale flush", {33'b0, frame_valid}, 34'd0);
    check("t4 count", {30'b0, dct_count}, 34'd1);
    exp_q.push_back({4'd1, 28'b0, 2'b11});
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    cyc();

    // T5: end-of-test drain
    m1 = '0;
    for (int i = 0; i < 5; i++) begin
      a  = 2'(i);
      m1 = {m1[27:0], a};
      send(a);
    end
    exp_q.push_back({4'd5, m1});
    test_ending = 1'b1;
    cyc();
    check("t5 drain atom_ready", {33'b0, atom_ready}, 34'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      seen = test_has_ended;
    end
    check("t5 test_has_ended", {33'b0, seen}, 34'd1);
    check("t5 count", {30'b0, dct_count}, 34'd0);
    atom_valid = 1'b1;
    atom_data  = 2'b01;
    flush      = 1'b1;
    cyc();
    atom_valid = 1'b0;
    flush      = 1'b0;
    cyc();
    cyc();
    check("t5 sticky", {33'b0, test_has_ended}, 34'd1);
    check("t5 done atom_ready", {33'b0, atom_ready}, 34'd0);
    check("t5 done count", {30'b0, dct_count}, 34'd0);

    // T6: reset mid-operation with a pending frame
    test_ending = 1'b0;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    check("t6 ended cleared", {33'b0, test_has_ended}, 34'd0);
    frame_ready = 1'b0;
    for (int i = 0; i < 22; i++) send(2'(i + 1));
    check("t6 count 7", {30'b0, dct_count}, 34'd7);
    check("t6 frame pending", {33'b0, frame_valid}, 34'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6 async frame_valid", {33'b0, frame_valid}, 34'd0);
    check("t6 async frame_data", frame_data, 34'd0);
    check("t6 async count", {30'b0, dct_count}, 34'd0);
    check("t6 async buffer", {4'b0, dct_buffer}, 34'd0);
    check("t6 async atom_ready", {33'b0, atom_ready}, 34'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    frame_ready = 1'b1;
    send(2'b01);
    send(2'b10);
    check("t6 resume count", {30'b0, dct_count}, 34'd2);
    exp_q.push_back({4'd2, 26'b0, 4'b0110});
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
    check("scoreboard drained", 34'(exp_q.size()), 34'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
